// File: rtl/lap_stopwatch.sv
// rtl/lap_stopwatch.sv - stopwatch core: run/stop/clear/lap/mode control, tick divider, lap FIFO
// Command-byte decoding is compiled in only when STOPWATCH_UART_CMD_EN is defined.
module lap_stopwatch #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int CNT_WIDTH = 14,
  parameter int CNT_MAX   = 9999,
  parameter int LAP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_run_stop,
  input  logic                 btn_clear,
  input  logic                 btn_lap,
  input  logic                 btn_mode,
  input  logic                 cmd_valid,
  input  logic [7:0]           cmd_data,
  output logic                 cmd_rd,
  input  logic                 lap_rd,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 running,
  output logic                 mode,
  output logic [CNT_WIDTH-1:0] lap_data,
  output logic                 lap_valid,
  output logic                 lap_ovf,
  output logic                 done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int LW  = $clog2(LAP_DEPTH) + 1;
  localparam logic [DW-1:0]        DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0]        DIV_ONE  = DW'(1);
  localparam logic [CNT_WIDTH-1:0] MAX_C    = CNT_WIDTH'(CNT_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE_C    = CNT_WIDTH'(1);
  localparam logic [LW-1:0]        DEPTH_C  = LW'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t               state, state_nx;
  logic [DW-1:0]        div_q, div_nx;
  logic [CNT_WIDTH-1:0] count_nx;
  logic                 mode_nx, done_nx;
  logic                 any_btn, tick;
  logic                 ev_clr, ev_rs, ev_lap, ev_mode;
  logic                 cmd_clr, cmd_rs, cmd_lap, cmd_mode;
  logic                 push, pop, push_ok;

  logic [CNT_WIDTH-1:0] lap_mem [LAP_DEPTH];
  logic [LW-1:0]        level, level_nx, wr_idx;

  assign any_btn = btn_run_stop | btn_clear | btn_lap | btn_mode;

`ifdef STOPWATCH_UART_CMD_EN
  // A button pulse blocks the byte so it is still there next cycle.
  assign cmd_rd = cmd_valid & ~any_btn;

  always_comb begin
    cmd_clr  = 1'b0;
    cmd_rs   = 1'b0;
    cmd_lap  = 1'b0;
    cmd_mode = 1'b0;
    case (cmd_data)
      8'h52, 8'h72: cmd_rs   = 1'b1;
      8'h43, 8'h63: cmd_clr  = 1'b1;
      8'h4c, 8'h6c: cmd_lap  = 1'b1;
      8'h4d, 8'h6d: cmd_mode = 1'b1;
      default:      ;
    endcase
  end
`else
  logic unused_cmd;
  assign cmd_rd     = 1'b0;
  assign cmd_clr    = 1'b0;
  assign cmd_rs     = 1'b0;
  assign cmd_lap    = 1'b0;
  assign cmd_mode   = 1'b0;
  assign unused_cmd = ^{cmd_valid, cmd_data};
`endif

  always_comb begin
    ev_clr  = btn_clear;
    ev_rs   = ~btn_clear & btn_run_stop;
    ev_lap  = ~btn_clear & ~btn_run_stop & btn_lap;
    ev_mode = ~btn_clear & ~btn_run_stop & ~btn_lap & btn_mode;
    if (cmd_rd) begin
      ev_clr  = cmd_clr;
      ev_rs   = cmd_rs;
      ev_lap  = cmd_lap;
      ev_mode = cmd_mode;
    end
  end

  assign tick = (state == RUN) && (div_q == DIV_LAST);

  always_comb begin
    state_nx = state;
    count_nx = count;
    div_nx   = div_q;
    mode_nx  = mode;
    done_nx  = 1'b0;

    if (state == RUN) begin
      div_nx = tick ? '0 : div_q + DIV_ONE;
    end

    if (tick) begin
      if (!mode) begin
        if (count == MAX_C) begin
          count_nx = '0;
          done_nx  = 1'b1;
        end else begin
          count_nx = count + ONE_C;
        end
      end else if (count <= ONE_C) begin
        count_nx = '0;
        done_nx  = 1'b1;
        state_nx = STOP;
      end else begin
        count_nx = count - ONE_C;
      end
    end

    if (ev_rs) begin
      if (state == RUN) begin
        state_nx = STOP;
      end else if (!(mode && count == '0)) begin
        state_nx = RUN;
        if (state == IDLE) div_nx = '0;
      end
    end

    if (ev_mode && state != RUN) mode_nx = ~mode;

    // Clear wins over everything, including a tick in the same cycle.
    if (ev_clr) begin
      state_nx = IDLE;
      count_nx = '0;
      div_nx   = '0;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      div_q   <= '0;
      mode    <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      div_q   <= div_nx;
      mode    <= mode_nx;
      done    <= done_nx;
      running <= (state_nx == RUN);
    end
  end

  // Shift-register FIFO: entry 0 is always the oldest, so lap_data is a flop.
  assign push     = ev_lap & (state != IDLE);
  assign pop      = lap_rd & (level != '0);
  assign wr_idx   = level - LW'(pop);
  assign push_ok  = push & (wr_idx != DEPTH_C);
  assign level_nx = wr_idx + LW'(push_ok);
  assign lap_data = lap_mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
      level     <= '0;
      lap_valid <= 1'b0;
      lap_ovf   <= 1'b0;
    end else if (ev_clr) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
      level     <= '0;
      lap_valid <= 1'b0;
      lap_ovf   <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < LAP_DEPTH - 1; i++) lap_mem[i] <= lap_mem[i+1];
      end
      if (push_ok) lap_mem[wr_idx[LW-2:0]] <= count;
      if (push && !push_ok) lap_ovf <= 1'b1;
      level     <= level_nx;
      lap_valid <= (level_nx != '0);
    end
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb/tb_lap_stopwatch.sv - directed and randomized bench for lap_stopwatch with a behavioural model
module tb_lap_stopwatch;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int CW        = 14;
  localparam int CNT_MAX   = 9;
  localparam int LAP_DEPTH = 4;
`ifdef STOPWATCH_UART_CMD_EN
  localparam bit CMD_EN = 1'b1;
`else
  localparam bit CMD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_run_stop, btn_clear, btn_lap, btn_mode;
  logic          cmd_valid;
  logic [7:0]    cmd_data;
  logic          cmd_rd;
  logic          lap_rd;
  logic [CW-1:0] count, lap_data;
  logic          running, mode, lap_valid, lap_ovf, done;

  always #5 clk = ~clk;

  lap_stopwatch #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CNT_WIDTH(CW), .CNT_MAX(CNT_MAX), .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_run_stop(btn_run_stop), .btn_clear(btn_clear), .btn_lap(btn_lap), .btn_mode(btn_mode),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_rd(cmd_rd), .lap_rd(lap_rd),
    .count(count), .running(running), .mode(mode), .lap_data(lap_data),
    .lap_valid(lap_valid), .lap_ovf(lap_ovf), .done(done)
  );

  int checks, errors;
  logic [7:0] src[$];
  logic       last_rd;
  logic [7:0] cmd_set [10] = '{"R", "r", "C", "c", "L", "l", "M", "m", "x", "?"};

  // Reference model: 0 idle, 1 run, 2 stop; run_cycles counts RUN cycles since the last divider reset.
  int  m_state, m_count, m_run;
  bit  m_mode, m_done, m_ovf;
  int  m_laps[$];

  task automatic model_reset();
    m_state = 0; m_count = 0; m_run = 0; m_mode = 0; m_done = 0; m_ovf = 0;
    m_laps.delete();
  endtask

  task automatic model_step();
    bit any_b, e_rd, e_clr, e_rs, e_lap, e_mode, tk;
    int pre, st;
    any_b  = btn_run_stop | btn_clear | btn_lap | btn_mode;
    e_rd   = CMD_EN && cmd_valid && !any_b;
    e_clr  = btn_clear;
    e_rs   = !btn_clear && btn_run_stop;
    e_lap  = !btn_clear && !btn_run_stop && btn_lap;
    e_mode = !btn_clear && !btn_run_stop && !btn_lap && btn_mode;
    if (e_rd) begin
      e_clr = (cmd_data == "C" || cmd_data == "c");
      e_rs  = (cmd_data == "R" || cmd_data == "r");
      e_lap = (cmd_data == "L" || cmd_data == "l");
      e_mode = (cmd_data == "M" || cmd_data == "m");
    end
    pre = m_count;
    st = m_state;
    m_done = 0;
    tk = (st == 1) && (m_run % DIV == DIV - 1);
    if (e_clr) begin
      m_state = 0; m_count = 0; m_run = 0; m_ovf = 0;
      m_laps.delete();
    end else begin
      if (st == 1) begin
        m_run++;
        if (tk && !m_mode) begin
          m_count = (pre == CNT_MAX) ? 0 : pre + 1;
          m_done = (pre == CNT_MAX);
        end else if (tk) begin
          m_count = pre - 1;
          if (m_count == 0) begin m_done = 1; m_state = 2; end
        end
      end
      if (lap_rd && m_laps.size() > 0) void'(m_laps.pop_front());
      if (e_lap && st != 0) begin
        if (m_laps.size() < LAP_DEPTH) m_laps.push_back(pre);
        else m_ovf = 1;
      end
      if (e_rs) begin
        if (st == 1) m_state = 2;
        else if (!(m_mode && pre == 0)) begin
          m_state = 1;
          if (st == 0) m_run = 0;
        end
      end
      if (e_mode && st != 1) m_mode = !m_mode;
    end
  endtask

  task automatic drive_src();
    cmd_valid = (src.size() > 0);
    cmd_data  = (src.size() > 0) ? src[0] : 8'h00;
  endtask

  task automatic step();
    model_step();
    #1 last_rd = cmd_rd;
    @(posedge clk);
    #1;
    if (last_rd && src.size() > 0) void'(src.pop_front());
    btn_run_stop = 0; btn_clear = 0; btn_lap = 0; btn_mode = 0; lap_rd = 0;
    drive_src();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (running !== 0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
    checks++; if (mode !== 0) begin errors++; $display("FAIL reset_mode got %b want 0", mode); end
    checks++; if (lap_valid !== 0) begin errors++; $display("FAIL reset_lap_valid got %b want 0", lap_valid); end
    checks++; if (lap_data !== 0) begin errors++; $display("FAIL reset_lap_data got %0d want 0", lap_data); end
    checks++; if (lap_ovf !== 0) begin errors++; $display("FAIL reset_lap_ovf got %b want 0", lap_ovf); end
    checks++; if (done !== 0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1;
    step();
  endtask

  task automatic test_run_stop();
    btn_run_stop = 1; step();
    run(35);
    checks++; if (count !== 3) begin errors++; $display("FAIL run_count got %0d want 3", count); end
    checks++; if (running !== 1) begin errors++; $display("FAIL run_running got %b want 1", running); end
    btn_run_stop = 1; step();
    for (int i = 0; i < 50; i++) begin
      step();
      checks++; if (count !== 3) begin errors++; $display("FAIL stop_hold cycle %0d got %0d want 3", i, count); end
    end
    checks++; if (running !== 0) begin errors++; $display("FAIL stop_running got %b want 0", running); end
  endtask

  task automatic test_up_wrap();
    int dn;
    bit saw9;
    dn = 0; saw9 = 0;
    btn_clear = 1; step();
    btn_run_stop = 1; step();
    for (int i = 0; i < 101; i++) begin
      step();
      if (done === 1'b1) dn++;
      if (count === 9) saw9 = 1;
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL wrap_done_cycles got %0d want 1", dn); end
    checks++; if (saw9 !== 1) begin errors++; $display("FAIL wrap_reached_max got %b want 1", saw9); end
    checks++; if (count !== 0) begin errors++; $display("FAIL wrap_count got %0d want 0", count); end
    checks++; if (running !== 1) begin errors++; $display("FAIL wrap_running got %b want 1", running); end
  endtask

  task automatic test_down();
    int dn;
    dn = 0;
    btn_clear = 1; step();
    btn_run_stop = 1; step();
    run(35);
    btn_run_stop = 1; step();
    checks++; if (count !== 3) begin errors++; $display("FAIL down_start got %0d want 3", count); end
    btn_mode = 1; step();
    checks++; if (mode !== 1) begin errors++; $display("FAIL down_mode got %b want 1", mode); end
    btn_run_stop = 1; step();
    checks++; if (running !== 1) begin errors++; $display("FAIL down_run got %b want 1", running); end
    repeat (30) begin
      step();
      if (done === 1'b1) dn++;
    end
    checks++; if (count !== 0) begin errors++; $display("FAIL down_count got %0d want 0", count); end
    checks++; if (running !== 0) begin errors++; $display("FAIL down_stopped got %b want 0", running); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL down_done_cycles got %0d want 1", dn); end
    btn_run_stop = 1; step(); step();
    checks++; if (running !== 0) begin errors++; $display("FAIL down_rs_ignored got %b want 0", running); end
  endtask

  task automatic test_cmd();
    int pulses, exp_pulses;
    pulses = 0;
    exp_pulses = CMD_EN ? 4 : 0;
    btn_clear = 1; step();
    btn_mode = 1; step();
    src.push_back("R"); src.push_back("x"); src.push_back("L"); src.push_back("c");
    drive_src();
    step(); pulses += int'(last_rd);
    checks++; if (running !== CMD_EN) begin errors++; $display("FAIL cmd_run got %b want %b", running, CMD_EN); end
    step(); pulses += int'(last_rd);
    step(); pulses += int'(last_rd);
    checks++; if (lap_valid !== CMD_EN) begin errors++; $display("FAIL cmd_lap_valid got %b want %b", lap_valid, CMD_EN); end
    checks++; if (lap_data !== 0) begin errors++; $display("FAIL cmd_lap_data got %0d want 0", lap_data); end
    step(); pulses += int'(last_rd);
    checks++; if (running !== 0) begin errors++; $display("FAIL cmd_clear_running got %b want 0", running); end
    checks++; if (lap_valid !== 0) begin errors++; $display("FAIL cmd_clear_flush got %b want 0", lap_valid); end
    repeat (2) begin step(); pulses += int'(last_rd); end
    checks++; if (pulses !== exp_pulses) begin errors++; $display("FAIL cmd_rd_pulses got %0d want %0d", pulses, exp_pulses); end
    src.delete(); drive_src();
  endtask

  task automatic test_cmd_block();
    src.push_back("R"); drive_src();
    btn_clear = 1;
    #1;
    checks++; if (cmd_rd !== 0) begin errors++; $display("FAIL block_cmd_rd got %b want 0", cmd_rd); end
    step();
    #1;
    checks++; if (cmd_rd !== CMD_EN) begin errors++; $display("FAIL block_next_rd got %b want %b", cmd_rd, CMD_EN); end
    step();
    checks++; if (running !== CMD_EN) begin errors++; $display("FAIL block_run got %b want %b", running, CMD_EN); end
    src.delete(); drive_src();
    btn_clear = 1; step();
  endtask

  task automatic test_lap_ovf();
    int want[4] = '{1, 2, 3, 5};
    btn_run_stop = 1; step();
    repeat (5) begin run(12); btn_lap = 1; step(); end
    checks++; if (lap_ovf !== 1) begin errors++; $display("FAIL ovf_flag got %b want 1", lap_ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (lap_data !== CW'(want[i])) begin errors++; $display("FAIL ovf_pop %0d got %0d want %0d", i, lap_data, want[i]); end
      lap_rd = 1; step();
    end
    checks++; if (lap_valid !== 0) begin errors++; $display("FAIL ovf_empty got %b want 0", lap_valid); end
    checks++; if (lap_ovf !== 1) begin errors++; $display("FAIL ovf_sticky got %b want 1", lap_ovf); end
  endtask

  task automatic test_back_to_back();
    int want[4] = '{3, 4, 5, 5};
    btn_clear = 1; step();
    checks++; if (lap_ovf !== 0) begin errors++; $display("FAIL b2b_ovf_cleared got %b want 0", lap_ovf); end
    btn_run_stop = 1; step();
    repeat (4) begin run(10); btn_lap = 1; step(); end
    run(10);
    btn_lap = 1; lap_rd = 1; step();
    checks++; if (lap_ovf !== 0) begin errors++; $display("FAIL b2b_full_pushpop_ovf got %b want 0", lap_ovf); end
    checks++; if (lap_data !== 2) begin errors++; $display("FAIL b2b_head got %0d want 2", lap_data); end
    run(4);
    btn_lap = 1; lap_rd = 1; step();
    checks++; if (count !== 6) begin errors++; $display("FAIL b2b_tick_count got %0d want 6", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (lap_data !== CW'(want[i])) begin errors++; $display("FAIL b2b_pop %0d got %0d want %0d", i, lap_data, want[i]); end
      lap_rd = 1; step();
    end
    lap_rd = 1; step();
    checks++; if (lap_valid !== 0) begin errors++; $display("FAIL b2b_empty_pop got %b want 0", lap_valid); end
    checks++; if (lap_ovf !== 0) begin errors++; $display("FAIL b2b_final_ovf got %b want 0", lap_ovf); end
    btn_clear = 1; step();
  endtask

  task automatic test_random();
    logic exp_rd;
    for (int i = 0; i < 3000 && errors < 40; i++) begin
      btn_clear    = ($urandom_range(0, 79) == 0);
      btn_run_stop = ($urandom_range(0, 24) == 0);
      btn_lap      = ($urandom_range(0, 7) == 0);
      btn_mode     = ($urandom_range(0, 15) == 0);
      lap_rd       = ($urandom_range(0, 5) == 0);
      if (src.size() < 3 && $urandom_range(0, 9) == 0) begin
        src.push_back(cmd_set[$urandom_range(0, 9)]);
        drive_src();
      end
      #1;
      exp_rd = CMD_EN & cmd_valid & ~(btn_clear | btn_run_stop | btn_lap | btn_mode);
      checks++; if (cmd_rd !== exp_rd) begin errors++; $display("FAIL rnd_cmd_rd cycle %0d got %b want %b", i, cmd_rd, exp_rd); end
      step();
      checks++; if (count !== CW'(m_count)) begin errors++; $display("FAIL rnd_count cycle %0d got %0d want %0d", i, count, m_count); end
      checks++; if (running !== (m_state == 1)) begin errors++; $display("FAIL rnd_running cycle %0d got %b want %b", i, running, m_state == 1); end
      checks++; if (mode !== m_mode) begin errors++; $display("FAIL rnd_mode cycle %0d got %b want %b", i, mode, m_mode); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done cycle %0d got %b want %b", i, done, m_done); end
      checks++; if (lap_ovf !== m_ovf) begin errors++; $display("FAIL rnd_lap_ovf cycle %0d got %b want %b", i, lap_ovf, m_ovf); end
      checks++; if (lap_valid !== (m_laps.size() > 0)) begin errors++; $display("FAIL rnd_lap_valid cycle %0d got %b want %b", i, lap_valid, m_laps.size() > 0); end
      if (m_laps.size() > 0) begin
        checks++; if (lap_data !== CW'(m_laps[0])) begin errors++; $display("FAIL rnd_lap_data cycle %0d got %0d want %0d", i, lap_data, m_laps[0]); end
      end
    end
    src.delete(); drive_src();
  endtask

  task automatic test_async_reset();
    btn_clear = 1; step();
    if (m_mode) begin btn_mode = 1; step(); end
    btn_run_stop = 1; step();
    run(15);
    checks++; if (count !== 1) begin errors++; $display("FAIL areset_pre_count got %0d want 1", count); end
    #2 rst_n = 0;
    #1;
    checks++; if (count !== 0) begin errors++; $display("FAIL areset_count got %0d want 0", count); end
    checks++; if (running !== 0) begin errors++; $display("FAIL areset_running got %b want 0", running); end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    step();
    checks++; if (count !== 0) begin errors++; $display("FAIL areset_release_count got %0d want 0", count); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 0; btn_run_stop = 0; btn_clear = 0; btn_lap = 0; btn_mode = 0; lap_rd = 0;
    cmd_valid = 0; cmd_data = 8'h00; last_rd = 0;
    model_reset();
    test_reset();
    test_run_stop();
    test_up_wrap();
    test_down();
    test_cmd();
    test_cmd_block();
    test_lap_ovf();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised stopwatch core: run/stop/clear/lap control from debounced buttons and from an ASCII command byte stream, configurable tick rate and count width, up/down mode, and a LAP_DEPTH-entry lap capture buffer. It sits between the button and UART-receive path (byte source with first-word-fall-through FIFO semantics) and the display/readout logic.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 100, count rate; DIV = CLK_HZ/TICK_HZ, DIV ≥ 2
- CNT_WIDTH, 14, width of count
- CNT_MAX, 9999, terminal count, < 2^CNT_WIDTH
- LAP_DEPTH, 4, lap buffer entries, power of two ≥ 2
- clk in 1: system clock, rising edge
- reset in 1: asynchronous, active-low reset
- btn_run_stop, btn_clear, btn_lap, btn_mode in 1 each: single-cycle debounced pulses
- cmd_valid in 1: byte available on cmd_data
- cmd_data in 8: command byte
- cmd_rd out 1: pop strobe to byte source (combinational)
- lap_rd in 1: pop oldest lap entry
- count out CNT_WIDTH: current count
- running out 1: state is RUN
- mode out 1: 0 up, 1 down
- lap_data out CNT_WIDTH: oldest lap entry (valid when lap_valid)
- lap_valid out 1: lap buffer not empty
- lap_ovf out 1: sticky, lap dropped because buffer full
- done out 1: one-cycle pulse, down-count reached 0 or up-count wrapped

## Operation
- FSM states IDLE, RUN, STOP; reset → IDLE.
- Events: RS (run/stop), CLR, LAP, MODE, each from button or command.
- Transitions: IDLE/STOP –RS→ RUN; RUN –RS→ STOP; any –CLR→ IDLE; RUN –down-count reaches 0→ STOP.
- Commands: 'R'/'r' → RS, 'C'/'c' → CLR, 'L'/'l' → LAP, 'M'/'m' → MODE; any other byte is popped and ignored.
- cmd_rd = cmd_valid & no button pulse this cycle; at most one byte consumed per cycle.
- Button events in a cycle take precedence over the command; the blocked byte stays in the source.
- Multiple simultaneous button events: priority CLR > RS > LAP > MODE; lower-priority events are dropped.
- CLR: count ← 0, divider ← 0, lap buffer flushed, lap_ovf ← 0; mode unchanged.
- MODE: accepted only in IDLE or STOP; ignored in RUN.
- Up mode: count increments per tick; at CNT_MAX, tick → count 0, done pulse, stays RUN.
- Down mode: count decrements per tick; tick at count 1 → count 0, done pulse, → STOP. RS in down mode with count 0 is ignored (stays IDLE/STOP).
- Divider runs only in RUN; it holds its value in STOP and resets to 0 on CLR and on IDLE→RUN.
- LAP in RUN or STOP: push count (pre-tick value if a tick occurs in the same cycle). LAP in IDLE is ignored.
- Lap buffer full on push: entry dropped, lap_ovf ← 1. Push and lap_rd in the same cycle while full: pop, then push succeeds.
- lap_rd when empty: no effect.

## Timing
- All outputs except cmd_rd are registered. Reset values: count 0, running 0, mode 0, lap_valid 0, lap_data 0, lap_ovf 0, done 0.
- Event in cycle N (button pulse or cmd_rd high): state and count update at edge N+1.
- First tick after IDLE→RUN occurs DIV cycles after running rises; ticks then follow every DIV cycles.
- Count and done update on the edge that ends the tick cycle.
- Lap push: lap_valid and lap_data are valid 1 cycle after the event. Pop: next entry appears 1 cycle after lap_rd.
- CLR in the same cycle as a tick: count = 0, tick lost.
- Reset assertion mid-operation: all state cleared immediately (asynchronous); release is synchronous to clk.

## Configuration
- STOPWATCH_UART_CMD_EN defined: command decoding active as described.
- Not defined: cmd_valid and cmd_data are ignored, cmd_rd is tied 0, and only buttons control the block.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10): btn_run_stop, wait 35 cycles → count=3, running=1; btn_run_stop → count holds 3 for 50 cycles.
- Up mode, CNT_MAX=9: run 100 cycles → count wraps 9→0, done pulse for exactly 1 cycle, running=1.
- Down mode from STOP, count=3: RS → after 30 cycles count=0, done=1, running=0; further RS ignored.
- cmd bytes 'R','x','L','c' with cmd_valid held → 4 cmd_rd pulses, lap entry captured, then count=0, buffer empty.
- btn_clear while cmd_valid high with 'R' → cmd_rd=0 that cycle; next cycle 'R' is consumed → RUN.
- LAP_DEPTH=4: 5 laps in RUN → lap_ovf=1; four pops return the first four values in order, then lap_valid=0.
